// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch AXI read master.
package fetch_pkg;

  typedef struct packed {
    logic [39:0] pc;
    logic [3:0]  offset;
    logic        err;
  } fifo_fetch_to_decode_param_t;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] ARPROT_DEFAULT  = 3'b100;

  localparam logic [2:0] ST_INIT        = 3'd0;
  localparam logic [2:0] ST_IDLE        = 3'd1;
  localparam logic [2:0] ST_AR          = 3'd2;
  localparam logic [2:0] ST_R           = 3'd3;
  localparam logic [2:0] ST_FLUSH_DRAIN = 3'd4;
  localparam logic [2:0] ST_ERROR       = 3'd5;

endpackage

// File: rtl/fetch_line_fifo.sv
// Synchronous line FIFO with registered read port, occupancy count and clear.
module fetch_line_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 173
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !clear && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !clear && (count != '0);

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr];
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

endmodule

// File: rtl/fetch_axi_master.sv
// AXI4 burst read master filling the instruction line FIFO.
// Define FETCH_SVA_EN to compile in protocol/behaviour assertions.
module fetch_axi_master
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 40,
  parameter int unsigned           DATA_WIDTH   = 128,
  parameter int unsigned           BURST_LENGTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR    = ADDR_WIDTH'(40'h0000_0001_0002),
  parameter int unsigned           FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    co_error,
  output logic                    co_reset_finish,
  input  logic                    ci_pause,
  input  logic                    ci_flush_request,
  output logic                    co_flush_response,
  input  logic [ADDR_WIDTH-1:0]   ci_addr,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    fetch_rd_en,
  output logic                    fetch_rd_valid,
  output logic [DATA_WIDTH-1:0]   fetch_instr,
  output logic [$bits(fifo_fetch_to_decode_param_t)-1:0] fetch_param,
  output logic                    fetch_empty
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
  localparam int unsigned BEAT_W     = $clog2(BURST_LENGTH);
  localparam int unsigned BLK_W      = OFF_W + BEAT_W;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PARAM_W    = $bits(fifo_fetch_to_decode_param_t);
  localparam int unsigned ENTRY_W    = DATA_WIDTH + PARAM_W;

  logic [2:0]            state, state_d;
  logic [ADDR_WIDTH-1:0] pc, flush_addr;
  logic [BEAT_W-1:0]     beat_idx, pc_beat;
  logic                  flush_pending, flush_req_q, flush_edge, flush_any;
  logic                  beat_c, beat_err, push_c, pop_c, clear_c, free_ok;
  logic [CNT_W-1:0]      count;
  fifo_fetch_to_decode_param_t push_param;
  logic [ENTRY_W-1:0]    push_entry, rd_entry;

  assign pc_beat    = pc[BLK_W-1:OFF_W];
  assign beat_c     = m_axi_rvalid && m_axi_rready;
  assign beat_err   = m_axi_rresp != RESP_OKAY;
  assign flush_edge = ci_flush_request && !flush_req_q;
  assign flush_any  = flush_pending || flush_edge;
  assign free_ok    = count <= CNT_W'(FIFO_DEPTH - BURST_LENGTH);
  assign pop_c      = fetch_rd_en && !ci_flush_request && !clear_c;
  assign fetch_empty = (count == '0);

  // Beats ahead of the PC line are skipped; only the first pushed beat carries the PC byte offset.
  always_comb begin
    push_param        = '0;
    push_param.pc     = 40'({m_axi_araddr[ADDR_WIDTH-1:BLK_W], beat_idx, OFF_W'(0)});
    push_param.offset = (beat_idx == pc_beat) ? 4'(pc[OFF_W-1:0]) : 4'd0;
    push_param.err    = beat_err;
  end
  assign push_entry = {m_axi_rdata, push_param};
  assign {fetch_instr, fetch_param} = rd_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    push_c  = 1'b0;
    clear_c = 1'b0;
    case (state)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (flush_pending) clear_c = 1'b1;
        else if (!ci_pause && !ci_flush_request && !co_error && free_ok) state_d = ST_AR;
      end
      ST_AR: begin
        if (m_axi_arready) state_d = flush_any ? ST_FLUSH_DRAIN : ST_R;
      end
      ST_R: begin
        push_c = beat_c && (beat_idx >= pc_beat) && !flush_any;
        if (beat_c && m_axi_rlast) state_d = (co_error || beat_err) ? ST_ERROR : ST_IDLE;
        else if (flush_any)        state_d = ST_FLUSH_DRAIN;
      end
      ST_FLUSH_DRAIN: begin
        if (beat_c && m_axi_rlast) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (flush_pending) begin
          clear_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                <= BOOT_ADDR;
      flush_addr        <= '0;
      flush_pending     <= 1'b0;
      flush_req_q       <= 1'b0;
      beat_idx          <= '0;
      co_error          <= 1'b0;
      co_reset_finish   <= 1'b0;
      co_flush_response <= 1'b0;
      m_axi_araddr      <= '0;
      m_axi_arlen       <= '0;
      m_axi_arsize      <= '0;
      m_axi_arburst     <= '0;
      m_axi_arcache     <= '0;
      m_axi_arprot      <= '0;
      m_axi_arqos       <= '0;
      m_axi_arregion    <= '0;
      m_axi_arvalid     <= 1'b0;
      m_axi_rready      <= 1'b0;
    end else begin
      co_reset_finish   <= 1'b1;
      co_flush_response <= clear_c;
      flush_req_q       <= ci_flush_request;
      m_axi_arlen       <= 8'(BURST_LENGTH - 1);
      m_axi_arsize      <= 3'(OFF_W);
      m_axi_arburst     <= BURST_INCR;
      m_axi_arcache     <= ARCACHE_DEFAULT;
      m_axi_arprot      <= ARPROT_DEFAULT;
      m_axi_arqos       <= 4'd0;
      m_axi_arregion    <= 4'd0;
      m_axi_arvalid     <= (state_d == ST_AR);
      m_axi_rready      <= (state_d == ST_R) || (state_d == ST_FLUSH_DRAIN);

      if (flush_edge) begin
        flush_pending <= 1'b1;
        flush_addr    <= ci_addr;
      end else if (clear_c) begin
        flush_pending <= 1'b0;
      end

      if (state == ST_IDLE && state_d == ST_AR)
        m_axi_araddr <= {pc[ADDR_WIDTH-1:BLK_W], BLK_W'(0)};

      if (state == ST_AR)  beat_idx <= '0;
      else if (beat_c)     beat_idx <= beat_idx + BEAT_W'(1);

      if (clear_c) begin
        pc       <= flush_addr;
        co_error <= 1'b0;
      end else begin
        if (state == ST_R && beat_c && m_axi_rlast)
          pc <= {m_axi_araddr[ADDR_WIDTH-1:BLK_W] + (ADDR_WIDTH-BLK_W)'(1), BLK_W'(0)};
        if (beat_c && beat_err) co_error <= 1'b1;
      end
    end
  end

  fetch_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_c),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .rd_valid  (fetch_rd_valid),
    .rd_data   (rd_entry),
    .count     (count)
  );

`ifdef FETCH_SVA_EN
  ar_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    m_axi_arvalid && !m_axi_arready |=> m_axi_arvalid && $stable(m_axi_araddr)
      && $stable(m_axi_arlen) && $stable(m_axi_arsize) && $stable(m_axi_arburst));
  no_push_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && count == CNT_W'(FIFO_DEPTH)));
  rvalid_state_a: assert property (@(posedge clk) disable iff (!rst_n)
    m_axi_rvalid |-> (state == ST_R || state == ST_FLUSH_DRAIN));
  flush_pulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    co_flush_response |=> !co_flush_response);
`endif

endmodule

// File: tb/tb_fetch_axi_master.sv
// Directed/randomized bench for fetch_axi_master with a behavioural AXI slave and line-stream model.
module tb_fetch_axi_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         co_error, co_reset_finish, co_flush_response;
  logic         ci_pause, ci_flush_request;
  logic [39:0]  ci_addr;
  logic [39:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize, m_axi_arprot;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic [3:0]   m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic         m_axi_arvalid, m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic         fetch_rd_en, fetch_rd_valid, fetch_empty;
  logic [127:0] fetch_instr;
  logic [44:0]  fetch_param;

  always #5 clk = ~clk;

  fetch_axi_master dut (
    .clk(clk), .rst_n(rst_n), .co_error(co_error), .co_reset_finish(co_reset_finish),
    .ci_pause(ci_pause), .ci_flush_request(ci_flush_request),
    .co_flush_response(co_flush_response), .ci_addr(ci_addr),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .fetch_rd_en(fetch_rd_en), .fetch_rd_valid(fetch_rd_valid), .fetch_instr(fetch_instr),
    .fetch_param(fetch_param), .fetch_empty(fetch_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected line stream: consecutive 16-byte lines from the start PC.
  logic [39:0] exp_line;
  logic [3:0]  exp_off;
  logic [39:0] err_line = 40'hFF_FFFF_FFF0;

  function automatic logic [127:0] mem_word(input logic [39:0] a);
    logic [31:0] x;
    x = a[31:0];
    return {x ^ 32'hA5A5_0000, ~x, x + 32'h1234_5678, x[15:0], x[31:16]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural AXI slave: random AR acceptance and R gaps, error on err_line.
  logic [39:0] ar_log [$];
  logic [27:0] ar_fields [$];
  logic        in_burst = 1'b0, ar_hs = 1'b0, r_acc = 1'b0;
  logic [39:0] cap_addr, burst_addr;
  logic [27:0] cap_fields;
  int          beat = 0;

  initial begin : slave
    logic [39:0] a;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (m_axi_rvalid && r_acc) begin
        beat++;
        if (beat == 4) in_burst = 1'b0;
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      if (ar_hs) begin
        ar_hs = 1'b0;
        m_axi_arready = 1'b0;
        ar_log.push_back(cap_addr);
        ar_fields.push_back(cap_fields);
        burst_addr = cap_addr;
        beat = 0;
        in_burst = 1'b1;
      end else if (!in_burst && m_axi_arvalid && $urandom_range(0, 1) == 1) begin
        m_axi_arready = 1'b1;
        ar_hs = 1'b1;
        cap_addr = m_axi_araddr;
        cap_fields = {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
                      m_axi_arprot, m_axi_arqos, m_axi_arregion};
      end
      if (in_burst && $urandom_range(0, 3) != 0) begin
        a = burst_addr + 40'(beat * 16);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(a);
        m_axi_rresp  = (a == err_line) ? 2'b10 : 2'b00;
        m_axi_rlast  = (beat == 3);
        r_acc        = m_axi_rready;
      end
    end
  end

  logic arvalid_q = 1'b0;
  int   ar_rises = 0;
  always @(posedge clk) begin
    arvalid_q <= m_axi_arvalid;
    if (m_axi_arvalid && !arvalid_q) ar_rises <= ar_rises + 1;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pop_check(input string tag);
    int t;
    t = 0;
    while (fetch_empty && t < 300) begin @(negedge clk); t++; end
    check({tag, "_avail"}, fetch_empty, 1'b0);
    fetch_rd_en = 1'b1;
    @(negedge clk);
    fetch_rd_en = 1'b0;
    check({tag, "_valid"}, fetch_rd_valid, 1'b1);
    check({tag, "_instr"}, fetch_instr, mem_word(exp_line));
    check({tag, "_param"}, fetch_param, {exp_line, exp_off, exp_line == err_line});
    exp_line = exp_line + 40'd16;
    exp_off  = 4'd0;
  endtask

  task automatic wait_ar(input int n);
    int t;
    t = 0;
    while (ar_log.size() < n && t < 300) begin @(negedge clk); t++; end
    check("ar_arrived", ar_log.size() >= n, 1'b1);
  endtask

  task automatic do_flush(input logic [39:0] addr, input logic with_pop);
    int t;
    ci_flush_request = 1'b1;
    ci_addr = addr;
    fetch_rd_en = with_pop;
    @(negedge clk);
    ci_flush_request = 1'b0;
    fetch_rd_en = 1'b0;
    if (with_pop) check("flush_pop_dropped", fetch_rd_valid, 1'b0);
    t = 0;
    while (!co_flush_response && t < 300) begin @(negedge clk); t++; end
    check("flush_resp_seen", co_flush_response, 1'b1);
    check("flush_empty", fetch_empty, 1'b1);
    check("flush_err_clear", co_error, 1'b0);
    @(negedge clk);
    check("flush_resp_pulse", co_flush_response, 1'b0);
    exp_line = {addr[39:4], 4'h0};
    exp_off  = addr[3:0];
  endtask

  initial begin : main
    int n, t, rises0;
    rst_n = 1'b0; ci_pause = 1'b0; ci_flush_request = 1'b0; ci_addr = '0; fetch_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_finish", co_reset_finish, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_empty", fetch_empty, 1'b1);
    check("rst_error", co_error, 1'b0);
    check("rst_rd_valid", fetch_rd_valid, 1'b0);
    rst_n = 1'b1;
    exp_line = 40'h1_0000;
    exp_off  = 4'h2;
    @(negedge clk);
    check("reset_finish", co_reset_finish, 1'b1);

    // First burst address and constant AR attributes.
    wait_ar(1);
    check("ar0_addr", ar_log[0], 40'h1_0000);
    check("ar0_fields", ar_fields[0], {8'd3, 3'd4, 2'b01, 4'b0011, 3'b100, 4'd0, 4'd0});

    // No pops: two bursts fill the FIFO, no third AR.
    repeat (100) @(negedge clk);
    check("fill_ar_count", ar_log.size(), 2);
    check("fill_ar1_addr", ar_log[1], 40'h1_0040);
    check("fill_arvalid", m_axi_arvalid, 1'b0);

    // Continuous pops, then next burst once slots free.
    for (int i = 0; i < 6; i++) pop_check("cpop");
    wait_ar(3);
    check("ar2_addr", ar_log[2], 40'h1_0080);

    // Pause: no new AR, in-flight burst completes, pops still served.
    ci_pause = 1'b1;
    rises0 = ar_rises;
    for (int i = 0; i < 10; i++) begin
      if (!fetch_empty) pop_check("pause_pop");
      else @(negedge clk);
    end
    t = 0;
    while ((in_burst || ar_hs || m_axi_arvalid) && t < 300) begin @(negedge clk); t++; end
    check("pause_inflight_done", in_burst || ar_hs || m_axi_arvalid, 1'b0);
    t = 0;
    while (!fetch_empty && t < 20) begin pop_check("pause_drain"); t++; end
    check("pause_empty", fetch_empty, 1'b1);
    fetch_rd_en = 1'b1;
    @(negedge clk);
    fetch_rd_en = 1'b0;
    check("empty_pop_ignored", fetch_rd_valid, 1'b0);
    repeat (5) @(negedge clk);
    check("pause_no_ar", ar_rises, rises0);
    n = ar_log.size();
    ci_pause = 1'b0;
    wait_ar(n + 1);
    check("resume_ar_addr", ar_log[n], {exp_line[39:6], 6'h0});

    // Flush during R with a simultaneous pop.
    t = 0;
    while (!m_axi_rready && t < 300) begin @(negedge clk); t++; end
    check("in_r_phase", m_axi_rready, 1'b1);
    do_flush(40'h1_0002, 1'b1);
    n = ar_log.size();
    wait_ar(n + 1);
    check("flush_ar_addr", ar_log[n], 40'h1_0000);
    for (int i = 0; i < 5; i++) pop_check("post_flush");

    // Error response: sticky flag, no new AR, flush clears.
    err_line = 40'h2_0020;
    do_flush(40'h2_0010, 1'b0);
    n = ar_log.size();
    wait_ar(n + 1);
    check("err_ar_addr", ar_log[n], 40'h2_0000);
    t = 0;
    while (!co_error && t < 300) begin @(negedge clk); t++; end
    check("err_set", co_error, 1'b1);
    repeat (30) @(negedge clk);
    check("err_sticky", co_error, 1'b1);
    check("err_no_ar", ar_log.size(), n + 1);
    check("err_arvalid", m_axi_arvalid, 1'b0);
    for (int i = 0; i < 3; i++) pop_check("err_pop");
    check("err_skip_leading", fetch_empty, 1'b1);
    err_line = 40'hFF_FFFF_FFF0;
    do_flush(40'h3_0000, 1'b0);
    n = ar_log.size();
    wait_ar(n + 1);
    check("recover_ar_addr", ar_log[n], 40'h3_0000);
    for (int i = 0; i < 2; i++) pop_check("recover_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
